rv32_decode_exec_forward_buffer: RTL and testbench
==================================================

RV32_DECODE_EXEC_FORWARD_BUFFER -- requirements
Module: rv32_decode_exec_forward_buffer

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode stage holds a valid instruction
- in_pc  in  32  PC of the decode instruction
- in_instr  in  32  raw decode instruction word
- rf_data  in  3x32  register file read data [0]=rs1, [1]=rs2, [2]=rd
- bypass_rs  in  3x2  per-operand select from hazard unit: 0=NO_BYPASS, 1=BYPASS_EXEC_BUFF, 2=BYPASS_MEM_BUFF, 3 reserved
- hdu_stall  in  1  load-use stall request from hazard unit
- exec_result  in  32  result currently leaving exec stage
- mem_result  in  32  result currently leaving mem stage
- exec_hold  in  1  downstream cannot accept; buffer must hold
- flush  in  1  control-flow redirect; kill decode and buffer contents
- out_valid  out  1  buffer holds a valid instruction for exec
- out_pc  out  32  registered PC
- out_instr  out  32  registered instruction word
- out_op  out  3x32  registered resolved operands, same index order as rf_data
- decode_ready  out  1  decode instruction consumed this cycle; fetch/decode may advance
- bubble  out  1  a load-use bubble was inserted this cycle
REQ-002 SHALL use reset exactly as decided: one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL resolve operand i combinationally: sel 0 or 3 -> rf_data[i]; sel 1 -> exec_result; sel 2 -> mem_result.
REQ-004 SHALL apply per-cycle priority: rst > flush > exec_hold > (hdu_stall & in_valid) > load.
REQ-005 Flush SHALL set out_valid=0, out_instr=0x00000013, out_op=0, out_pc=0 on the next edge; decode_ready=1, bubble=0 that cycle.
REQ-006 Hold (exec_hold=1, no flush) SHALL keep all registered outputs unchanged; decode_ready=0; bubble=0.
REQ-007 Load-use (hdu_stall=1, in_valid=1, no hold/flush) SHALL insert a bubble: out_valid=0, out_instr=0x00000013, out_op=0, out_pc unchanged; decode_ready=0; bubble=1.
REQ-008 Load (otherwise) SHALL register out_valid=in_valid, out_pc=in_pc, out_instr=in_instr, out_op=resolved operands; decode_ready=1.
REQ-009 hdu_stall with in_valid=0 SHALL be ignored (normal load of an invalid slot, bubble=0).
REQ-010 Latency decode->exec SHALL be exactly 1 cycle when not held or stalled; a load-use stall SHALL cost exactly one bubble cycle provided hdu_stall deasserts.
REQ-011 decode_ready and bubble SHALL be combinational from the current-cycle inputs; all other outputs registered.
REQ-012 Operand resolution SHALL occur in the load cycle only; a held entry SHALL NOT re-sample bypass sources.

Reset
REQ-013 On rst: out_valid=0, out_pc=0, out_instr=0x00000013, out_op all 0, perf counters 0.
REQ-014 rst asserted mid-hold or mid-stall SHALL discard the buffered instruction; first post-reset cycle behaves as an empty buffer.
REQ-015 During rst, decode_ready=0 and bubble=0.

Configuration
REQ-016 Macro RV32_FWD_PERF_EN SHALL add outputs perf_bubbles (32), perf_holds (32) and input perf_clear (1).
REQ-017 With it: perf_bubbles increments on each bubble cycle, perf_holds on each REQ-006 cycle; both saturate at 0xFFFFFFFF; perf_clear zeroes both synchronously, overriding increment.
REQ-018 Without it: ports and counters absent; all other behaviour identical.

Verification
REQ-019 Reset, then in_valid=1, in_pc=0x100, sel all 0, rf_data={1,2,3} -> next cycle out_valid=1, out_pc=0x100, out_op={1,2,3}.
REQ-020 sel={1,2,0}, exec_result=0xAA, mem_result=0xBB, rf_data[2]=0xCC -> out_op={0xAA,0xBB,0xCC}.
REQ-021 hdu_stall=1 one cycle with in_valid=1 -> bubble=1, decode_ready=0, out_valid=0, out_instr=0x00000013; next cycle same instruction loads.
REQ-022 exec_hold=1 three cycles with buffer valid, rf_data changing -> outputs frozen, decode_ready=0; perf_holds=3 when RV32_FWD_PERF_EN.
REQ-023 flush=1 with exec_hold=1 and hdu_stall=1 -> next cycle out_valid=0, decode_ready=1, bubble=0.
REQ-024 rst asserted during hold -> next cycle out_valid=0, all outputs at reset values.

Source files
------------

// File: rtl/rv32_decode_exec_forward_buffer.sv
// ---------------------------------------------------------------------------
// rv32_decode_exec_forward_buffer
//
// Decode->exec pipeline register that resolves operand forwarding at load
// time. Each of the three operands (rs1, rs2, rd) comes from the register
// file, the exec-stage result or the mem-stage result, as chosen by the
// hazard unit. The resolved values are captured together with PC and
// instruction.
//
// Per-cycle priority: rst > flush > exec_hold > load-use bubble > load.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/pc/instr decode-stage instruction
//   rf_data[95:0]     RF read data, [31:0]=rs1 [63:32]=rs2 [95:64]=rd
//   bypass_rs[5:0]    2-bit select per operand, same order as rf_data
//   hdu_stall         load-use stall request
//   exec_result       result leaving exec
//   mem_result        result leaving mem
//   exec_hold         downstream stall, freeze the buffer
//   flush             kill buffer contents
//   out_*             registered instruction, PC and resolved operands
//   decode_ready      decode instruction consumed this cycle (combinational)
//   bubble            load-use bubble inserted this cycle (combinational)
//
// Optional feature, enabled by defining RV32_FWD_PERF_EN:
//   perf_clear (in), perf_bubbles / perf_holds (out, saturating counters)
// ---------------------------------------------------------------------------
module rv32_decode_exec_forward_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic [95:0] rf_data,
  input  logic [5:0]  bypass_rs,
  input  logic        hdu_stall,
  input  logic [31:0] exec_result,
  input  logic [31:0] mem_result,
  input  logic        exec_hold,
  input  logic        flush,
`ifdef RV32_FWD_PERF_EN
  input  logic        perf_clear,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_holds,
`endif
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [95:0] out_op,
  output logic        decode_ready,
  output logic        bubble
);

  localparam logic [31:0] Nop = 32'h0000_0013;  // addi x0, x0, 0

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [95:0] op_q, op_d;
  logic [95:0] op_resolved;
  logic        do_hold;
  logic        do_bubble;

  // Operand forwarding mux; select value 3 is reserved and reads the RF.
  always_comb begin
    op_resolved = '0;
    for (int i = 0; i < 3; i++) begin
      case (bypass_rs[i*2 +: 2])
        2'd1:    op_resolved[i*32 +: 32] = exec_result;
        2'd2:    op_resolved[i*32 +: 32] = mem_result;
        default: op_resolved[i*32 +: 32] = rf_data[i*32 +: 32];
      endcase
    end
  end

  // Control decode; flush outranks hold, hold outranks the load-use stall.
  always_comb begin
    do_hold      = !flush && exec_hold;
    do_bubble    = !flush && !exec_hold && hdu_stall && in_valid;
    decode_ready = !rst && !do_hold && !do_bubble;
    bubble       = !rst && do_bubble;
  end

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    op_d    = op_q;
    if (flush) begin
      valid_d = 1'b0;
      pc_d    = '0;
      instr_d = Nop;
      op_d    = '0;
    end else if (do_hold) begin
      // Keep everything, including operands: no re-sampling of bypass sources.
    end else if (do_bubble) begin
      // PC is kept so the bubble still carries a meaningful address.
      valid_d = 1'b0;
      instr_d = Nop;
      op_d    = '0;
    end else begin
      valid_d = in_valid;
      pc_d    = in_pc;
      instr_d = in_instr;
      op_d    = op_resolved;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= Nop;
      op_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      op_q    <= op_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign out_op    = op_q;

`ifdef RV32_FWD_PERF_EN
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_holds_q, perf_holds_d;

  // Saturating event counters; clear wins over a same-cycle increment.
  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_holds_d   = perf_holds_q;
    if (perf_clear) begin
      perf_bubbles_d = '0;
      perf_holds_d   = '0;
    end else begin
      if (do_bubble && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
        perf_bubbles_d = perf_bubbles_q + 32'd1;
      end
      if (do_hold && (perf_holds_q != 32'hFFFF_FFFF)) begin
        perf_holds_d = perf_holds_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubbles_q <= '0;
      perf_holds_q   <= '0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_holds_q   <= perf_holds_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_holds   = perf_holds_q;
`endif

endmodule

// File: tb/tb_rv32_decode_exec_forward_buffer.sv
// Scoreboarded directed bench for rv32_decode_exec_forward_buffer. Each step
// drives one cycle of inputs and queues the values expected mid-cycle:
// combinational outputs for the current inputs, registered outputs as left
// by the previous edge. A monitor pops and compares on every falling edge.
module tb_rv32_decode_exec_forward_buffer;

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam logic [31:0] I1  = 32'h00A0_0093;
  localparam logic [31:0] I2  = 32'h0020_81B3;
  localparam logic [31:0] I3  = 32'h0000_A183;
  localparam logic [31:0] I4  = 32'h0031_8233;
  localparam logic [31:0] I5  = 32'h0040_02B3;
  localparam logic [31:0] I6  = 32'h0052_8333;
  localparam logic [31:0] I7  = 32'h0063_03B3;

  logic        clk = 1'b1;
  logic        rst, in_valid, hdu_stall, exec_hold, flush;
  logic [31:0] in_pc, in_instr, exec_result, mem_result;
  logic [31:0] rf0, rf1, rf2;
  logic [1:0]  s0, s1, s2;
  logic [95:0] rf_data;
  logic [5:0]  bypass_rs;
  logic        out_valid, decode_ready, bubble;
  logic [31:0] out_pc, out_instr;
  logic [95:0] out_op;
  logic        perf_clear;
  logic [31:0] perf_bubbles, perf_holds;

  assign rf_data   = {rf2, rf1, rf0};
  assign bypass_rs = {s2, s1, s0};

  always #5 clk = ~clk;

  rv32_decode_exec_forward_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .rf_data      (rf_data),
    .bypass_rs    (bypass_rs),
    .hdu_stall    (hdu_stall),
    .exec_result  (exec_result),
    .mem_result   (mem_result),
    .exec_hold    (exec_hold),
    .flush        (flush),
`ifdef RV32_FWD_PERF_EN
    .perf_clear   (perf_clear),
    .perf_bubbles (perf_bubbles),
    .perf_holds   (perf_holds),
`endif
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_op       (out_op),
    .decode_ready (decode_ready),
    .bubble       (bubble)
  );

`ifndef RV32_FWD_PERF_EN
  assign perf_bubbles = '0;
  assign perf_holds   = '0;
`endif

  typedef struct {
    int          id;
    bit          regs;
    logic        rdy, bub, ov;
    logic [31:0] pc, instr, o0, o1, o2;
    bit          pchk;
    logic [31:0] pb, ph;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step%0d %s actual=%h required=%h", id, name, act, req);
    end
  endtask

  // Monitor: mid-cycle, away from the rising edge.
  always begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("decode_ready", e.id, {31'd0, decode_ready}, {31'd0, e.rdy});
      cmp("bubble", e.id, {31'd0, bubble}, {31'd0, e.bub});
      if (e.regs) begin
        cmp("out_valid", e.id, {31'd0, out_valid}, {31'd0, e.ov});
        cmp("out_pc", e.id, out_pc, e.pc);
        cmp("out_instr", e.id, out_instr, e.instr);
        cmp("out_op0", e.id, out_op[31:0], e.o0);
        cmp("out_op1", e.id, out_op[63:32], e.o1);
        cmp("out_op2", e.id, out_op[95:64], e.o2);
      end
`ifdef RV32_FWD_PERF_EN
      if (e.pchk) begin
        cmp("perf_bubbles", e.id, perf_bubbles, e.pb);
        cmp("perf_holds", e.id, perf_holds, e.ph);
      end
`endif
    end
  end

  int step_id = 0;

  task automatic step(input bit regs, input logic rdy, input logic bub, input logic ov,
                      input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
                      input bit pchk = 1'b0, input logic [31:0] pb = '0,
                      input logic [31:0] ph = '0);
    exp_t e;
    e.id = step_id; e.regs = regs; e.rdy = rdy; e.bub = bub; e.ov = ov;
    e.pc = pc; e.instr = instr; e.o0 = o0; e.o1 = o1; e.o2 = o2;
    e.pchk = pchk; e.pb = pb; e.ph = ph;
    q.push_back(e);
    step_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v; in_pc = pc; in_instr = instr; rf0 = r0; rf1 = r1; rf2 = r2;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; exec_hold = 1'b0; hdu_stall = 1'b0; perf_clear = 1'b0;
    exec_result = 32'hAA; mem_result = 32'hBB;
    s0 = 2'd0; s1 = 2'd0; s2 = 2'd0;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    // 0: first reset cycle, registers not yet defined
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    // 1: reset held with valid+stall on the input: no ready, no bubble
    set_in(1'b1, 32'h100, I1, 32'd1, 32'd2, 32'd3);
    hdu_stall = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, Nop, 0, 0, 0, 1'b1, 0, 0);
    // 2: plain load from the RF
    rst = 1'b0; hdu_stall = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, Nop, 0, 0, 0, 1'b1, 0, 0);
    // 3: forwarding rs1<-exec, rs2<-mem, rd<-rf
    set_in(1'b1, 32'h104, I2, 32'h11, 32'h22, 32'hCC);
    s0 = 2'd1; s1 = 2'd2; s2 = 2'd0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, I1, 32'd1, 32'd2, 32'd3);
    // 4: load-use stall
    set_in(1'b1, 32'h108, I3, 32'd4, 32'd5, 32'd6);
    s0 = 2'd0; s1 = 2'd0; s2 = 2'd0; hdu_stall = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h104, I2, 32'hAA, 32'hBB, 32'hCC);
    // 5: stall released, same instruction loads; bubble visible (PC kept)
    hdu_stall = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h104, Nop, 0, 0, 0, 1'b1, 32'd1, 0);
    // 6..8: three hold cycles, inputs changing underneath
    set_in(1'b1, 32'h10C, I4, 32'd7, 32'd8, 32'd9);
    exec_hold = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h108, I3, 32'd4, 32'd5, 32'd6);
    rf0 = 32'h70; rf1 = 32'h80; rf2 = 32'h90;
    s0 = 2'd1; s1 = 2'd1; s2 = 2'd1; exec_result = 32'hDD;
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h108, I3, 32'd4, 32'd5, 32'd6);
    hdu_stall = 1'b1;  // hold outranks the stall
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h108, I3, 32'd4, 32'd5, 32'd6);
    // 9: hold released, load I4
    exec_hold = 1'b0; hdu_stall = 1'b0;
    s0 = 2'd0; s1 = 2'd0; s2 = 2'd0;
    rf0 = 32'd7; rf1 = 32'd8; rf2 = 32'd9;
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h108, I3, 32'd4, 32'd5, 32'd6, 1'b1, 32'd1, 32'd3);
    // 10: flush beats hold and stall
    flush = 1'b1; exec_hold = 1'b1; hdu_stall = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h10C, I4, 32'd7, 32'd8, 32'd9);
    // 11: stall with in_valid=0 is ignored
    flush = 1'b0; exec_hold = 1'b0; hdu_stall = 1'b1;
    set_in(1'b0, 32'h200, I5, 32'd1, 32'd1, 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, Nop, 0, 0, 0);
    // 12: reserved select reads the RF; perf counters cleared
    hdu_stall = 1'b0; perf_clear = 1'b1;
    set_in(1'b1, 32'h110, I6, 32'hA, 32'hB, 32'hC);
    s0 = 2'd3; s1 = 2'd0; s2 = 2'd3;
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, I5, 32'd1, 32'd1, 32'd1);
    // 13: hold
    perf_clear = 1'b0; exec_hold = 1'b1;
    s0 = 2'd0; s2 = 2'd0;
    set_in(1'b1, 32'h114, I7, 32'd0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h110, I6, 32'hA, 32'hB, 32'hC, 1'b1, 0, 0);
    // 14: reset during hold
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h110, I6, 32'hA, 32'hB, 32'hC, 1'b1, 0, 32'd1);
    // 15: post-reset: empty buffer
    rst = 1'b0; exec_hold = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, Nop, 0, 0, 0, 1'b1, 0, 0);
    // 16: idle load of an invalid, zero slot
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending entries", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
